// File: rtl/object_display_multi.sv
// Pac-Man + N ghost compositor with per-frame collision, scoring, frightened mode, lives and game FSM.
// Build option OBJ_DISP_EXTRA_LIFE_EN: one bonus life on the first score update reaching 10000.
module object_display_multi #(
    parameter int N_GHOST       = 4,
    parameter int COORD_W       = 10,
    parameter int SCORE_W       = 16,
    parameter int PELLET_PTS    = 10,
    parameter int POWER_PTS     = 50,
    parameter int GHOST_PTS     = 200,
    parameter int FRIGHT_FRAMES = 360,
    parameter int DEATH_FRAMES  = 120,
    parameter int LIVES_INIT    = 3
) (
    input  logic                       p_tick,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       sw,
    input  logic                       video_on,
    input  logic [COORD_W-1:0]         p_x,
    input  logic [COORD_W-1:0]         p_y,
    input  logic [COORD_W-1:0]         pacman_l,
    input  logic [COORD_W-1:0]         pacman_r,
    input  logic [COORD_W-1:0]         pacman_t,
    input  logic [COORD_W-1:0]         pacman_b,
    input  logic [N_GHOST*COORD_W-1:0] ghost_l,
    input  logic [N_GHOST*COORD_W-1:0] ghost_r,
    input  logic [N_GHOST*COORD_W-1:0] ghost_t,
    input  logic [N_GHOST*COORD_W-1:0] ghost_b,
    input  logic [N_GHOST-1:0]         ghost_en,
    input  logic                       pellet_eaten,
    input  logic                       power_eaten,
    output logic [11:0]                rgb,
    output logic [SCORE_W-1:0]         score,
    output logic [2:0]                 lives,
    output logic                       fright,
    output logic [N_GHOST-1:0]         ghost_eaten,
    output logic                       game_over
);
    localparam int FT_W = $clog2(FRIGHT_FRAMES + 1);
    localparam int DT_W = $clog2(DEATH_FRAMES + 1);

    typedef enum logic [1:0] {S_PLAY, S_DYING, S_OVER} state_t;

    state_t             state, state_n;
    logic [FT_W-1:0]    ftimer, ftimer_n;
    logic [DT_W-1:0]    death_cnt, death_n;
    logic [1:0]         chain, chain_n, chain_run;
    logic [SCORE_W-1:0] score_n;
    logic [2:0]         lives_n;
    logic [N_GHOST-1:0] geaten_n, overlap, ghost_hit;
    logic [31:0]        pts;
    logic [11:0]        pix_p0;
    logic               pac_hit, died;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = 33'(a) + 33'(b);
        return (sum > 33'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    // Frightened ghosts flash white on odd 8-frame blocks once fewer than 120 frames remain.
    function automatic logic [11:0] ghost_colour(input int idx, input logic [FT_W-1:0] t);
        if (t != '0)
            return (32'(t) < 32'd120 && (32'(t) / 32'd8) % 32'd2 == 32'd1) ? 12'hFFF : 12'h00F;
        case (idx % 4)
            0:       return 12'hF00;
            1:       return 12'hFAC;
            2:       return 12'h0FF;
            default: return 12'hFA0;
        endcase
    endfunction

    for (genvar i = 0; i < N_GHOST; i++) begin : g_ghost
        logic [COORD_W-1:0] gl, gr, gt, gb;
        assign gl = ghost_l[i*COORD_W +: COORD_W];
        assign gr = ghost_r[i*COORD_W +: COORD_W];
        assign gt = ghost_t[i*COORD_W +: COORD_W];
        assign gb = ghost_b[i*COORD_W +: COORD_W];
        assign overlap[i]   = ghost_en[i] && pacman_l <= gr && gl <= pacman_r &&
                              pacman_t <= gb && gt <= pacman_b;
        assign ghost_hit[i] = ghost_en[i] && p_x >= gl && p_x <= gr && p_y >= gt && p_y <= gb;
    end

    assign pac_hit   = p_x >= pacman_l && p_x <= pacman_r && p_y >= pacman_t && p_y <= pacman_b;
    assign fright    = ftimer != '0;
    assign game_over = state == S_OVER;

    always_comb begin
        pix_p0 = 12'h000;
        if (video_on) begin
            if (pac_hit && state != S_DYING)
                pix_p0 = 12'hFF0;
            else
                for (int i = N_GHOST - 1; i >= 0; i--)
                    if (ghost_hit[i]) pix_p0 = ghost_colour(i, ftimer);
        end
    end

`ifdef OBJ_DISP_EXTRA_LIFE_EN
    logic bonus_done, bonus_n;
`endif

    always_comb begin
        state_n   = state;
        ftimer_n  = ftimer;
        death_n   = death_cnt;
        chain_n   = chain;
        chain_run = chain;
        lives_n   = lives;
        geaten_n  = '0;
        pts       = '0;
        died      = 1'b0;
`ifdef OBJ_DISP_EXTRA_LIFE_EN
        bonus_n   = bonus_done;
`endif
        if (!sw) begin
            case (state)
                S_PLAY: begin
                    if (pellet_eaten) pts = pts + 32'(PELLET_PTS);
                    if (power_eaten)  pts = pts + 32'(POWER_PTS);
                    if (frame_tick && |overlap) begin
                        if (!fright) begin
                            died = 1'b1;
                        end else begin
                            for (int i = 0; i < N_GHOST; i++) begin
                                if (overlap[i]) begin
                                    pts = pts + (32'(GHOST_PTS) << chain_run);
                                    if (chain_run != 2'd3) chain_run = chain_run + 2'd1;
                                end
                            end
                            geaten_n = overlap;
                            chain_n  = chain_run;
                        end
                    end
                    if (frame_tick && fright) begin
                        ftimer_n = ftimer - FT_W'(1);
                        if (ftimer == FT_W'(1)) chain_n = '0;
                    end
                    if (power_eaten) begin
                        ftimer_n = FT_W'(FRIGHT_FRAMES);
                        chain_n  = '0;
                    end
                    // A death cancels any fright state set up in the same cycle.
                    if (died) begin
                        lives_n  = lives - 3'd1;
                        death_n  = DT_W'(DEATH_FRAMES);
                        state_n  = S_DYING;
                        ftimer_n = '0;
                        chain_n  = '0;
                    end
                end
                S_DYING: begin
                    if (frame_tick) begin
                        if (death_cnt <= DT_W'(1)) begin
                            death_n = '0;
                            state_n = (lives == 3'd0) ? S_OVER : S_PLAY;
                        end else begin
                            death_n = death_cnt - DT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
        score_n = sat_add(score, pts);
`ifdef OBJ_DISP_EXTRA_LIFE_EN
        if (!bonus_done && 32'(score) < 32'd10000 && 32'(score_n) >= 32'd10000) begin
            bonus_n = 1'b1;
            lives_n = (lives_n == 3'd7) ? 3'd7 : lives_n + 3'd1;
        end
`endif
    end

    always_ff @(posedge p_tick) begin
        if (!rst) begin
            state       <= S_PLAY;
            score       <= '0;
            lives       <= 3'(LIVES_INIT);
            ftimer      <= '0;
            death_cnt   <= '0;
            chain       <= '0;
            ghost_eaten <= '0;
            rgb         <= 12'h000;
        end else begin
            state       <= state_n;
            score       <= score_n;
            lives       <= lives_n;
            ftimer      <= ftimer_n;
            death_cnt   <= death_n;
            chain       <= chain_n;
            ghost_eaten <= geaten_n;
            rgb         <= pix_p0;
        end
    end

`ifdef OBJ_DISP_EXTRA_LIFE_EN
    always_ff @(posedge p_tick) begin
        if (!rst) bonus_done <= 1'b0;
        else      bonus_done <= bonus_n;
    end
`endif
endmodule
